// File: rtl/inline_writecontrol.sv
// Write-side line-buffer controller: takes a line command, then streams pixel beats
// into the port-A interface of the selected mesh row's banks (bank b = m*X_MAC + j).
module inline_writecontrol #(
    parameter int X_MAC        = 4,
    parameter int X_MESH       = 16,
    parameter int ADDR_LEN     = 13,
    parameter int DATA_LEN     = 32,
    parameter int MAX_LINE_LEN = 10,
    parameter int MESH_W       = $clog2(X_MESH),
    parameter int IDLE_SOON_TH = 10,
    parameter int BUFFER_NUM   = X_MAC * X_MESH,
    parameter int DATAWIDTH    = BUFFER_NUM * DATA_LEN,
    parameter int ADDRWIDTH    = BUFFER_NUM * ADDR_LEN
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_LEN*X_MAC-1:0]    st_addr,
    input  logic [MAX_LINE_LEN-1:0]      linelen,
    input  logic [MESH_W-1:0]            mesh_sel,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [DATA_LEN*X_MAC-1:0]    din,
    input  logic                         din_valid,
    output logic                         din_ready,
    output logic [ADDRWIDTH-1:0]         addra,
    output logic [BUFFER_NUM-1:0]        wea,
    output logic [DATAWIDTH-1:0]         dina,
    output logic                         busy,
    output logic                         idle_soon,
    output logic                         done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                      state_reg;
    logic [ADDR_LEN*X_MAC-1:0]   base_reg;
    logic [MESH_W-1:0]           row_reg;
    logic                        row_ok_reg;
    logic [MAX_LINE_LEN-1:0]     beats_left_reg;
    logic [MAX_LINE_LEN-1:0]     beat_cnt_reg;
    logic                        done_reg;
    logic                        beat_fire;

    assign beat_fire = (state_reg == RUN) && din_valid;

    assign cmd_ready = (state_reg == IDLE);
    assign din_ready = (state_reg == RUN);
    assign busy      = (state_reg != IDLE);
    assign idle_soon = (state_reg == IDLE) || (32'(beats_left_reg) < IDLE_SOON_TH);
    assign done      = done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            row_reg        <= '0;
            row_ok_reg     <= 1'b0;
            beats_left_reg <= '0;
            beat_cnt_reg   <= '0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        base_reg       <= st_addr;
                        row_reg        <= mesh_sel;
                        // Out-of-range rows still consume the line but never write.
                        row_ok_reg     <= (32'(mesh_sel) < X_MESH);
                        beats_left_reg <= linelen;
                        beat_cnt_reg   <= '0;
                        if (linelen == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (din_valid) begin
                        beats_left_reg <= beats_left_reg - MAX_LINE_LEN'(1);
                        beat_cnt_reg   <= beat_cnt_reg + MAX_LINE_LEN'(1);
                        if (beats_left_reg == MAX_LINE_LEN'(1)) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Each bank registers its own port-A signals; address/data hold while not written.
    genvar gi;
    generate
        for (gi = 0; gi < BUFFER_NUM; gi++) begin : g_bank
            localparam int MROW = gi / X_MAC;
            localparam int LANE = gi % X_MAC;

            logic                bank_hit;
            logic                wea_b_reg;
            logic [ADDR_LEN-1:0] addr_b_reg;
            logic [DATA_LEN-1:0] data_b_reg;

            assign bank_hit = beat_fire && row_ok_reg && (32'(row_reg) == MROW);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wea_b_reg  <= 1'b0;
                    addr_b_reg <= '0;
                    data_b_reg <= '0;
                end else begin
                    wea_b_reg <= bank_hit;
                    if (bank_hit) begin
                        addr_b_reg <= base_reg[LANE*ADDR_LEN +: ADDR_LEN] + ADDR_LEN'(beat_cnt_reg);
                        data_b_reg <= din[LANE*DATA_LEN +: DATA_LEN];
                    end
                end
            end

            assign wea[gi]                         = wea_b_reg;
            assign addra[gi*ADDR_LEN +: ADDR_LEN]  = addr_b_reg;
            assign dina[gi*DATA_LEN +: DATA_LEN]   = data_b_reg;
        end
    endgenerate

endmodule
